// File: rtl/fpga_cfg_loader_if.sv
// Serial-in / configuration-write bus between the bitstream source and the
// fpga_cfg_loader. The master modport is the loader side, the slave modport
// is the source/fabric side.
//
// Handshake: sin is consumed only on a rising clk edge where sin_valid=1;
// there is no back-pressure, so the loader accepts every valid bit. cfg_we is
// a one-cycle strobe and cfg_addr/cfg_data are valid whenever it is high;
// the fabric must accept the write in that cycle.
interface fpga_cfg_loader_if #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 32
);
    logic              sin;
    logic              sin_valid;
    logic              cfg_clear;
    logic [ADDR_W-1:0] cfg_addr;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_we;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    modport master (
        input  sin, sin_valid, cfg_clear,
        output cfg_addr, cfg_data, cfg_we, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        output sin, sin_valid, cfg_clear,
        input  cfg_addr, cfg_data, cfg_we, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: deserialises the configuration bitstream into addressed
// words and writes them into the fabric's configuration space.
//
// Frame (MSB-first): SYNC[7:0] | addr[ADDR_W-1:0] | data[WORD_W-1:0] [| par]
// Define CFG_PARITY_EN to add a trailing parity bit; the XOR of the address,
// data and parity bits must then be 0, otherwise the frame is dropped and
// cfg_err is raised. Without the macro there is no parity bit and cfg_err
// only reports out-of-range addresses.
//
// dbg_state exposes the FSM encoding (0 HUNT, 1 ADDR, 2 DATA, 3 PAR).
module fpga_cfg_loader #(
    parameter int         WORD_W    = 32,
    parameter int         ADDR_W    = 4,
    parameter int         NUM_WORDS = 15,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    fpga_cfg_loader_if.master   bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    localparam int                CNT_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]   NUM_LIM   = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [NUM_WORDS-1:0] ONE_HOT0 = {{(NUM_WORDS-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [7:0]             win;
    logic [ADDR_W-1:0]      addr_sr;
    logic [WORD_W-1:0]      data_sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [NUM_WORDS-1:0]   loaded;

    logic [7:0]             win_next;
    logic                   sync_hit;
    logic [ADDR_W-1:0]      addr_next;
    logic [WORD_W-1:0]      data_next;
    logic                   addr_in_range;
    logic [NUM_WORDS-1:0]   loaded_next;

    logic                   commit_go;
    logic [WORD_W-1:0]      commit_word;
    logic                   frame_ok;

    assign win_next      = {win[6:0], bus.sin};
    assign sync_hit      = (win_next == SYNC);
    assign addr_next     = {addr_sr[ADDR_W-2:0], bus.sin};
    assign data_next     = {data_sr[WORD_W-2:0], bus.sin};
    assign addr_in_range = ({1'b0, addr_sr} < NUM_LIM);
    assign loaded_next   = loaded | (ONE_HOT0 << addr_sr);

    assign bus.cfg_busy  = (state != HUNT);
    assign dbg_state     = state;

    // Detect the edge that samples the last bit of a frame and decide what
    // word it carries and whether the frame is intact.
    always_comb begin
        commit_go   = 1'b0;
        commit_word = data_next;
        frame_ok    = 1'b1;
`ifdef CFG_PARITY_EN
        if (bus.sin_valid && state == PAR) begin
            commit_go   = 1'b1;
            commit_word = data_sr;
            frame_ok    = ~(^{addr_sr, data_sr, bus.sin});
        end
`else
        if (bus.sin_valid && state == DATA && bit_cnt == DATA_LAST) begin
            commit_go = 1'b1;
        end
`endif
    end

    // Frame FSM, shift registers, loaded mask and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            win          <= '0;
            addr_sr      <= '0;
            data_sr      <= '0;
            bit_cnt      <= '0;
            loaded       <= '0;
            bus.cfg_addr <= '0;
            bus.cfg_data <= '0;
            bus.cfg_we   <= 1'b0;
            bus.cfg_done <= 1'b0;
            bus.cfg_err  <= 1'b0;
        end else if (bus.cfg_clear) begin
            // cfg_addr/cfg_data deliberately keep the last written word.
            state        <= HUNT;
            win          <= '0;
            addr_sr      <= '0;
            data_sr      <= '0;
            bit_cnt      <= '0;
            loaded       <= '0;
            bus.cfg_we   <= 1'b0;
            bus.cfg_done <= 1'b0;
            bus.cfg_err  <= 1'b0;
        end else begin
            bus.cfg_we <= 1'b0;
            if (bus.sin_valid) begin
                case (state)
                    HUNT: begin
                        if (sync_hit) begin
                            state   <= ADDR;
                            win     <= '0;
                            bit_cnt <= '0;
                        end else begin
                            win <= win_next;
                        end
                    end
                    ADDR: begin
                        addr_sr <= addr_next;
                        if (bit_cnt == ADDR_LAST) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        data_sr <= data_next;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef CFG_PARITY_EN
                            state   <= PAR;
`else
                            state   <= HUNT;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PAR: begin
                        state <= HUNT;
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase

                // Commit on the same edge that samples the final frame bit;
                // the window is already clear, so hunting resumes next bit.
                if (commit_go) begin
                    win <= '0;
                    if (!frame_ok || !addr_in_range) begin
                        bus.cfg_err <= 1'b1;
                    end else begin
                        bus.cfg_addr <= addr_sr;
                        bus.cfg_data <= commit_word;
                        bus.cfg_we   <= 1'b1;
                        loaded       <= loaded_next;
                        if (&loaded_next) begin
                            bus.cfg_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Serial configuration loader upstream of the `fpga` fabric.
- Receives the bitstream on `sin`, frames it into addressed 32-bit words, and issues one-cycle write strobes into the fabric's 15-entry configuration space.
- Config space layout:
  - words 0-9: LUT memories
  - word 10: B switch boxes
  - word 11: L1
  - word 12: C switch boxes
  - word 13: E1
  - word 14: D1
- Signals `cfg_done` once every word has been written at least once.

Parameters:
- WORD_W, 32, configuration word width
- ADDR_W, 4, word-address field width
- NUM_WORDS, 15, number of valid configuration words (addresses 0..NUM_WORDS-1)
- SYNC, 8'hA5, frame sync pattern

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial configuration bit
- sin_valid  input  1  sin is sampled only on cycles where this is 1
- cfg_clear  input  1  synchronous clear of loaded mask, error flag and FSM
- cfg_addr  output  ADDR_W  target word address
- cfg_data  output  WORD_W  target word data
- cfg_we  output  1  one-cycle write strobe
- cfg_busy  output  1  high while in ADDR/DATA/PAR states
- cfg_done  output  1  all NUM_WORDS words written
- cfg_err  output  1  sticky error flag

Behaviour:
- Reset: async on rst_n low. FSM=HUNT; all outputs 0; sync window, shift register, bit counter and loaded mask all 0.
- Bit order: all fields MSB-first. Only cycles with sin_valid=1 advance any state or counter.
- HUNT:
  - 8-bit sliding window shifts in sin.
  - When {window[6:0],sin}==SYNC, go to ADDR (overlapping patterns are detected).
- ADDR: collect ADDR_W bits, then go to DATA.
- DATA:
  - Collect WORD_W bits.
  - On the last bit: go to PAR if CFG_PARITY_EN is defined, otherwise commit.
- PAR: one bit, then commit.
- Commit, all on the same edge that samples the final bit:
  - Address check:
    - addr < NUM_WORDS: register cfg_addr/cfg_data; cfg_we=1 for the next cycle only; set loaded[addr].
    - addr >= NUM_WORDS: no write; cfg_err<=1.
  - FSM returns to HUNT with the window cleared, so no bit after the frame is lost.
- Latency: cfg_we is high in the cycle after the final frame bit was sampled.
- cfg_addr and cfg_data hold their value until the next commit.
- Rewriting an already-loaded address is legal: a new cfg_we is issued and the mask is unchanged.
- cfg_done:
  - Registered; becomes 1 the cycle after loaded becomes all-ones, i.e. the same cycle as the final cfg_we.
  - Stays 1 until cfg_clear or reset.
  - Frames received after done are still written.
- cfg_busy = (state != HUNT).
- sin_valid=0 mid-frame: the frame stalls indefinitely with no timeout.
- cfg_clear:
  - Takes priority over everything in the same cycle.
  - FSM<=HUNT; loaded, cfg_done, cfg_err, window and counters <=0; cfg_we<=0.
  - cfg_addr and cfg_data are left unchanged.
- rst_n asserted mid-frame: immediate return to reset state; the partial frame is discarded.
- cfg_err is sticky; only cfg_clear or reset clears it.

Optional Feature:
- Macro: CFG_PARITY_EN.
- Defined:
  - Each frame carries one extra bit after the data.
  - Even parity over address+data+parity bits must be 0.
  - On mismatch: no write, loaded unchanged, cfg_err<=1, return to HUNT.
- Undefined:
  - No PAR state; frame length is 8+ADDR_W+WORD_W bits.
  - cfg_err is set only by an out-of-range address.

Test Plan:
- Reset, then frame A5 | 4'h0 | 32'h0000FF00 with sin_valid held 1 -> cfg_we one cycle after the last bit; cfg_addr=0, cfg_data=0000FF00; cfg_done=0; cfg_busy low after the frame.
- Stream all 15 frames (word n = 0000FF00, 00000100 ... FFFFFF00, 00000000, 00000814, 00000248, 00000001) in shuffled order, back-to-back -> 15 strobes with matching addr/data; cfg_done=1 coincident with the 15th cfg_we.
- Frame with addr 4'hF, then a valid frame -> no strobe for the first, cfg_err=1; the second is written and cfg_err stays 1.
- Random sin_valid gaps (~50%) plus garbage bits such as 8'h5A before the sync -> identical writes to the gap-free run; garbage produces no strobe.
- Assert rst_n low mid-DATA, then cfg_clear after done -> all outputs 0 immediately on reset; after clear cfg_done=0, cfg_err=0; the next frame decodes correctly.
- With CFG_PARITY_EN defined, frame addr 3, data 00000800 with wrong parity -> no cfg_we, cfg_err=1; the same frame with correct parity -> written.
